// File: rtl/mux_n_arb.sv
`default_nettype none
// ============================================================================
// mux_n_arb : N-input registered select/round-robin mux with valid/ready
// Revision  : 1.0
// ============================================================================
module mux_n_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [NUM_IN*DATA_WIDTH-1:0] MuxIn,
  input  logic [NUM_IN-1:0]            InValid,
  output logic [NUM_IN-1:0]            InReady,
  input  logic [SEL_WIDTH-1:0]         Sel,
  input  logic                         Mode,
  output logic [DATA_WIDTH-1:0]        MuxOut,
  output logic [SEL_WIDTH-1:0]         OutSel,
  output logic                         OutValid,
  input  logic                         OutReady
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] mux_out_q, mux_out_d;
  logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;
  logic [SEL_WIDTH-1:0]  last_q, last_d;

  logic                  load_en;
  logic                  transfer;
  logic [SEL_WIDTH-1:0]  grant;
  logic                  grant_valid;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  rr_found;
  int                    rr_idx;

  assign load_en  = !out_valid_q || OutReady;
  assign transfer = load_en && grant_valid && !Reset;

  // Mode 1 searches Last+1, Last+2, ... so the most recent winner is last in line.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    rr_found    = 1'b0;
    rr_idx      = 0;
    if (!Mode) begin
      grant = Sel;
      for (int i = 0; i < NUM_IN; i++) begin
        if (Sel == SEL_WIDTH'(i)) grant_valid = InValid[i];
      end
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        rr_idx = (int'(last_q) + k) % NUM_IN;
        if (!rr_found && InValid[rr_idx]) begin
          grant    = SEL_WIDTH'(rr_idx);
          rr_found = 1'b1;
        end
      end
      grant_valid = rr_found;
    end
  end

  always_comb begin
    grant_data = '0;
    InReady    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_WIDTH'(i)) begin
        grant_data = MuxIn[i*DATA_WIDTH +: DATA_WIDTH];
        InReady[i] = transfer;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    mux_out_d   = mux_out_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      mux_out_d   = grant_data;
      out_sel_d   = grant;
      if (Mode) last_d = grant;
    end else if (OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      mux_out_q   <= '0;
      out_sel_q   <= '0;
      last_q      <= SEL_WIDTH'(NUM_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      mux_out_q   <= mux_out_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign OutValid = out_valid_q;
  assign MuxOut   = mux_out_q;
  assign OutSel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_n_arb.sv
`default_nettype none
// ============================================================================
// tb_mux_n_arb : directed self-checking bench for mux_n_arb (NUM_IN=4 and 3)
// Revision     : 1.0
// ============================================================================
module tb_mux_n_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [127:0] mux_in;
  logic [3:0]  in_valid, in_ready;
  logic [1:0]  sel, out_sel;
  logic        mode, out_valid, out_ready;
  logic [31:0] mux_out;

  logic [95:0] mux_in3;
  logic [2:0]  in_valid3, in_ready3;
  logic [1:0]  sel3, out_sel3;
  logic        mode3, out_valid3, out_ready3;
  logic [31:0] mux_out3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] chan_data [4];
  logic [1:0]  rr_seq [6];

  always #5 clk = ~clk;

  mux_n_arb #(.DATA_WIDTH(32), .NUM_IN(4), .SEL_WIDTH(2)) dut (
    .Clk(clk), .Reset(rst), .MuxIn(mux_in), .InValid(in_valid), .InReady(in_ready),
    .Sel(sel), .Mode(mode), .MuxOut(mux_out), .OutSel(out_sel),
    .OutValid(out_valid), .OutReady(out_ready)
  );

  mux_n_arb #(.DATA_WIDTH(32), .NUM_IN(3), .SEL_WIDTH(2)) dut3 (
    .Clk(clk), .Reset(rst), .MuxIn(mux_in3), .InValid(in_valid3), .InReady(in_ready3),
    .Sel(sel3), .Mode(mode3), .MuxOut(mux_out3), .OutSel(out_sel3),
    .OutValid(out_valid3), .OutReady(out_ready3)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_chans();
    for (int i = 0; i < 4; i++) mux_in[i*32 +: 32] = chan_data[i];
  endtask

  initial begin
    chan_data[0] = 32'hA0; chan_data[1] = 32'hB1;
    chan_data[2] = 32'hC2; chan_data[3] = 32'hD3;
    rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd3;
    rr_seq[3] = 2'd0; rr_seq[4] = 2'd1; rr_seq[5] = 2'd3;
    load_chans();
    rst = 1'b1; in_valid = 4'hF; sel = 2'd0; mode = 1'b1; out_ready = 1'b1;
    mux_in3 = {32'h33, 32'h22, 32'h11}; in_valid3 = 3'b111; sel3 = 2'd3;
    mode3 = 1'b0; out_ready3 = 1'b1;

    // Reset held two cycles with every channel valid
    step();
    check_eq("rst_ready_c1", 64'(in_ready), 64'h0);
    step();
    check_eq("rst_ready_c2", 64'(in_ready), 64'h0);
    check_eq("rst_valid", 64'(out_valid), 64'h0);
    check_eq("rst_data", 64'(mux_out), 64'h0);
    check_eq("rst_sel", 64'(out_sel), 64'h0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_rr_ready", 64'(in_ready), 64'h1);

    // Mode 0 sweep
    mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check_eq("m0_ready", 64'(in_ready), 64'(4'b0001 << s));
      step();
      check_eq("m0_data", 64'(mux_out), 64'(chan_data[s]));
      check_eq("m0_sel", 64'(out_sel), 64'(s));
      check_eq("m0_valid", 64'(out_valid), 64'h1);
    end

    // Round-robin with channel 2 idle; Last still 3 after mode-0 traffic
    mode = 1'b1; in_valid = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("rr_sel", 64'(out_sel), 64'(rr_seq[k]));
      check_eq("rr_valid", 64'(out_valid), 64'h1);
    end

    // Back-pressure on a word from channel 1
    chan_data[1] = 32'h55; load_chans();
    in_valid = 4'b0010;
    step();
    check_eq("bp_load_data", 64'(mux_out), 64'h55);
    check_eq("bp_load_sel", 64'(out_sel), 64'h1);
    out_ready = 1'b0; in_valid = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("bp_ready", 64'(in_ready), 64'h0);
      step();
      check_eq("bp_data", 64'(mux_out), 64'h55);
      check_eq("bp_sel", 64'(out_sel), 64'h1);
      check_eq("bp_valid", 64'(out_valid), 64'h1);
    end
    in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 64'(in_ready), 64'b0100);
    step();
    check_eq("bp_release_data", 64'(mux_out), 64'hC2);
    check_eq("bp_release_sel", 64'(out_sel), 64'h2);
    check_eq("bp_release_valid", 64'(out_valid), 64'h1);

    // Mode 0 with the selected channel idle: drain, hold data
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1101;
    #1;
    check_eq("m0_idle_ready", 64'(in_ready), 64'h0);
    step();
    check_eq("m0_idle_valid", 64'(out_valid), 64'h0);
    check_eq("m0_idle_hold_data", 64'(mux_out), 64'hC2);
    check_eq("m0_idle_hold_sel", 64'(out_sel), 64'h2);

    // Mode 0 then switch to mode 1: Last (=2) was kept through mode 0
    sel = 2'd0; in_valid = 4'hF;
    step();
    check_eq("sw_m0_data", 64'(mux_out), 64'hA0);
    mode = 1'b1;
    #1;
    check_eq("sw_m1_ready", 64'(in_ready), 64'b1000);
    step();
    check_eq("sw_m1_sel_a", 64'(out_sel), 64'h3);
    step();
    check_eq("sw_m1_sel_b", 64'(out_sel), 64'h0);

    // Reset mid-operation; Last is 0 beforehand, so a kept pointer would pick channel 2
    mode = 1'b0; sel = 2'd1; chan_data[1] = 32'h1234; load_chans();
    in_valid = 4'b0010;
    step();
    check_eq("mid_load_data", 64'(mux_out), 64'h1234);
    out_ready = 1'b0; in_valid = 4'b0000; rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_valid", 64'(out_valid), 64'h0);
    check_eq("mid_rst_data", 64'(mux_out), 64'h0);
    check_eq("mid_rst_sel", 64'(out_sel), 64'h0);
    mode = 1'b1; in_valid = 4'b0101; out_ready = 1'b1;
    #1;
    check_eq("mid_rst_rr_ready", 64'(in_ready), 64'b0001);
    step();
    check_eq("mid_rst_rr_sel", 64'(out_sel), 64'h0);
    check_eq("mid_rst_rr_data", 64'(mux_out), 64'hA0);

    // NUM_IN=3 with Sel=3 has never been readied
    for (int k = 0; k < 3; k++) begin
      check_eq("n3_sel3_ready", 64'(in_ready3), 64'h0);
      check_eq("n3_sel3_valid", 64'(out_valid3), 64'h0);
      step();
    end
    sel3 = 2'd2;
    #1;
    check_eq("n3_sel2_ready", 64'(in_ready3), 64'b100);
    step();
    check_eq("n3_sel2_data", 64'(mux_out3), 64'h33);
    check_eq("n3_sel2_sel", 64'(out_sel3), 64'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_n_arb.md
Name: mux_n_arb

Overview:
- Parametrised successor to the datapath 4:1 select mux. Selects one of NUM_IN input channels onto a registered output, with a valid/ready handshake on every channel.
- Two modes:
  - Mode 0 (select): the channel is chosen by an external Sel, as in the existing mux.
  - Mode 1 (round-robin): the block arbitrates among the channels that are requesting.
- Sits between multicycle datapath sources (ALUOut, memory data, immediates) and shared sinks such as the register-file write port or the memory request path.

Parameters:
- DATA_WIDTH, 32, width of each data channel.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_WIDTH, 2, width of Sel and OutSel; must equal ceil(log2(NUM_IN)).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- MuxIn  input  NUM_IN*DATA_WIDTH  packed channel data; channel i is MuxIn[i*DATA_WIDTH +: DATA_WIDTH].
- InValid  input  NUM_IN  per-channel valid.
- InReady  output  NUM_IN  per-channel ready; combinational; at most one bit high.
- Sel  input  SEL_WIDTH  channel choice in mode 0; ignored in mode 1.
- Mode  input  1  0 = select, 1 = round-robin.
- MuxOut  output  DATA_WIDTH  registered output data.
- OutSel  output  SEL_WIDTH  index of the channel that produced MuxOut.
- OutValid  output  1  MuxOut holds an untaken word.
- OutReady  input  1  sink accepts MuxOut.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high; it is sampled on the Clk rising edge.
- Reset values: OutValid=0, MuxOut=0, OutSel=0. The internal round-robin pointer Last=NUM_IN-1, so channel 0 is first in priority after reset. Reset overrides all other activity in the same cycle, and a word in flight is dropped.
- Output register:
  - load_en = !OutValid | OutReady.
  - A transfer on channel g occurs when InValid[g] & InReady[g].
  - InReady[g] = load_en & grant_valid & (grant == g).
- Latency: a word accepted in cycle N appears on MuxOut with OutValid=1 in cycle N+1.
- Throughput: one word per cycle when OutReady is held at 1.
- Output stall: while OutValid=1 and OutReady=0, MuxOut and OutSel hold their values and every InReady bit is 0.
- Drain with no new word: if OutValid=1, OutReady=1 and there is no grant, OutValid goes to 0 on the next edge. MuxOut and OutSel hold their last values.
- Mode 0 (select):
  - grant = Sel; grant_valid = InValid[Sel].
  - If Sel >= NUM_IN, grant_valid=0 and no channel is ever readied.
  - The Last pointer is not updated by mode-0 transfers.
- Mode 1 (round-robin):
  - grant is the first index with InValid set, searching Last+1, Last+2, … with wrap modulo NUM_IN.
  - grant_valid is 1 when any InValid bit is set.
  - On a transfer, Last <= grant. With no transfer, Last holds.
- Mode switching:
  - Mode is sampled combinationally each cycle, and a change applies to the same cycle's arbitration.
  - Last is retained across mode changes.
  - The registered output word is unaffected by a mode change.
- Source rule: InValid must not depend combinationally on InReady. Data on MuxIn is captured only in the transfer cycle.
- Simultaneous drain and load: OutReady=1 with OutValid=1 and a grant in the same cycle loads the new word. OutValid stays 1, with no bubble.

Test Plan:
- Reset and idle: assert Reset for 2 cycles with all InValid=1 → OutValid=0, MuxOut=0, OutSel=0 and InReady=0 during reset. In the first cycle after reset in Mode=1, InReady=4'b0001.
- Mode 0 pass-through: NUM_IN=4, channel data 0xA0,0xB1,0xC2,0xD3, all InValid=1, OutReady=1. Sweep Sel through 0,1,2,3 → MuxOut is 0xA0,0xB1,0xC2,0xD3 one cycle later, OutSel matches Sel, and exactly one InReady bit follows Sel.
- Round-robin fairness: Mode=1, InValid=4'b1011 held, OutReady=1 → OutSel sequence is 0,1,3,0,1,3. Channel 2 is never granted, and OutValid stays 1 continuously.
- Back-pressure: Mode=1, word 0x55 from channel 1 in the output register, OutReady=0 for 5 cycles → MuxOut=0x55, OutSel=1 held and InReady=0 throughout. When OutReady rises, the next word loads the same cycle with no bubble.
- Mode 0 edge cases:
  - InValid[Sel]=0 → no InReady, and OutValid goes to 0 after the drain.
  - NUM_IN=3 with Sel=3 → never readied.
  - Switch to Mode=1 mid-stream → arbitration resumes from the retained Last pointer.
- Reset mid-operation: OutValid=1 holding 0x1234 with OutReady=0, assert Reset one cycle → OutValid=0, MuxOut=0, Last=NUM_IN-1. The next Mode=1 grant goes to the lowest valid channel.
